// File: rtl/scan_mux_pkg.sv
// ============================================================================
// scan_mux_pkg : shared state encoding and width helper for scan_mux
// Revision     : 1.0
// ============================================================================
`default_nettype none

package scan_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   // A zero-width counter is illegal, so one-state ranges still get a bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/scan_mux_dwell_ctr.sv
// ============================================================================
// scan_mux_dwell_ctr : modulo-DWELL counter with clear and terminal count
// Revision           : 1.0
// ============================================================================
`default_nettype none

module scan_mux_dwell_ctr
   import scan_mux_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);

   localparam int            CW     = clog2_min1(DWELL);
   localparam logic [CW-1:0] C_LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc_o = (cnt_q == C_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/scan_mux.sv
// ============================================================================
// scan_mux : registered N-channel mux with manual select and auto-scan modes
// Revision : 1.0
// ============================================================================
`default_nettype none

module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int W     = 2,
   parameter int N     = 4,
   parameter int DWELL = 4,
   localparam int SW   = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] din,
   input  logic [SW-1:0]  sel,
   input  logic           mode,
   input  logic           en,
   output logic [W-1:0]   y,
   output logic [SW-1:0]  ch,
   output logic           y_valid,
   output logic           wrap
);

   localparam logic [SW-1:0] C_LAST = SW'(N - 1);
   localparam logic [SW:0]   C_N    = (SW + 1)'(N);

   state_e        state_q, state_d;
   logic [W-1:0]  y_q, y_d;
   logic [SW-1:0] ch_q, ch_d;
   logic          valid_q, valid_d;
   logic          wrap_q, wrap_d;
   logic          w_ctr_inc;
   logic          w_ctr_tc;
   logic          w_step;

   function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == SW'(k)) r = d[k*W +: W];
      end
      return r;
   endfunction

   // Counting starts only once SCAN is already registered, so the first
   // channel after entry is shown for a full DWELL cycles like all others.
   assign w_ctr_inc = (state_d == ST_SCAN) && (state_q == ST_SCAN);
   assign w_step    = w_ctr_inc && w_ctr_tc;

   scan_mux_dwell_ctr #(
      .DWELL (DWELL)
   ) u_dwell_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!w_ctr_inc),
      .inc_i (w_ctr_inc),
      .tc_o  (w_ctr_tc)
   );

   always_comb begin
      state_d = ST_IDLE;
      ch_d    = ch_q;
      y_d     = '0;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (en) state_d = mode ? ST_SCAN : ST_MANUAL;

      case (state_d)
         ST_MANUAL: begin
            if ({1'b0, sel} < C_N) begin
               ch_d    = sel;
               y_d     = pick(din, sel);
               valid_d = 1'b1;
            end
         end
         ST_SCAN: begin
            if (w_step) begin
               ch_d   = (ch_q == C_LAST) ? '0 : ch_q + 1'b1;
               wrap_d = (ch_q == C_LAST);
            end
            y_d     = pick(din, ch_d);
            valid_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign y       = y_q;
   assign ch      = ch_q;
   assign y_valid = valid_q;
   assign wrap    = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux.sv
// ============================================================================
// tb_scan_mux : directed vector bench for scan_mux (W=2, N=4/3, DWELL=4/1)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_scan_mux;

   localparam logic [7:0] C_DIN4 = 8'b11_10_01_00;
   localparam logic [5:0] C_DIN3 = 6'b10_01_00;

   logic clk;

   // main instance: N=4, DWELL=4
   logic       rst0, en0, mode0;
   logic [1:0] sel0;
   logic [7:0] din0;
   logic [1:0] y0, ch0;
   logic       v0, w0;

   // N=3, DWELL=4
   logic       rst3, en3, mode3;
   logic [1:0] sel3;
   logic [5:0] din3;
   logic [1:0] y3, ch3;
   logic       v3, w3;

   // N=4, DWELL=1
   logic       rst1, en1, mode1;
   logic [1:0] sel1;
   logic [7:0] din1;
   logic [1:0] y1, ch1;
   logic       v1, w1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       rst, en, mode;
      logic [1:0] sel;
      logic [1:0] y, ch;
      logic       v, w;
   } vec_t;

   vec_t vecs[$];

   scan_mux #(.W(2), .N(4), .DWELL(4)) dut (
      .clk(clk), .rst(rst0), .din(din0), .sel(sel0), .mode(mode0), .en(en0),
      .y(y0), .ch(ch0), .y_valid(v0), .wrap(w0));

   scan_mux #(.W(2), .N(3), .DWELL(4)) dut3 (
      .clk(clk), .rst(rst3), .din(din3), .sel(sel3), .mode(mode3), .en(en3),
      .y(y3), .ch(ch3), .y_valid(v3), .wrap(w3));

   scan_mux #(.W(2), .N(4), .DWELL(1)) dut1 (
      .clk(clk), .rst(rst1), .din(din1), .sel(sel1), .mode(mode1), .en(en1),
      .y(y1), .ch(ch1), .y_valid(v1), .wrap(w1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic r, input logic e, input logic m, input logic [1:0] s,
                               input logic [1:0] ey, input logic [1:0] ec, input logic ev, input logic ew);
      vec_t t;
      t.rst = r; t.en = e; t.mode = m; t.sel = s;
      t.y = ey; t.ch = ec; t.v = ev; t.w = ew;
      vecs.push_back(t);
   endfunction

   initial begin
      // ---------------- vector table for the N=4, DWELL=4 instance ----------
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 4; s++)
         for (int r = 0; r < 4; r++)
            add(0, 1, 0, 2'(s), 2'(s), 2'(s), 1, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0);                       // rst beats en/mode
      for (int k = 0; k < 26; k++)
         add(0, 1, 1, 0, 2'((k / 4) % 4), 2'((k / 4) % 4), 1, (k == 16));
      for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 2, 0, 0);
      for (int k = 0; k < 4; k++) add(0, 1, 1, 0, 2, 2, 1, 0);
      add(0, 1, 1, 0, 3, 3, 1, 0);
      add(0, 1, 1, 0, 3, 3, 1, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0);                       // rst at ch=3
      add(0, 1, 1, 0, 0, 0, 1, 0);
      add(0, 1, 0, 1, 1, 1, 1, 0);                       // scan -> manual
      add(0, 1, 1, 0, 1, 1, 1, 0);                       // manual -> scan keeps ch

      rst0 = 1; en0 = 0; mode0 = 0; sel0 = 0; din0 = C_DIN4;
      rst3 = 1; en3 = 0; mode3 = 0; sel3 = 0; din3 = C_DIN3;
      rst1 = 1; en1 = 0; mode1 = 0; sel1 = 0; din1 = C_DIN4;

      foreach (vecs[i]) begin
         rst0 = vecs[i].rst; en0 = vecs[i].en; mode0 = vecs[i].mode; sel0 = vecs[i].sel;
         tick();
         chk($sformatf("vec%0d y", i),    32'(y0), 32'(vecs[i].y));
         chk($sformatf("vec%0d ch", i),   32'(ch0), 32'(vecs[i].ch));
         chk($sformatf("vec%0d vld", i),  32'(v0), 32'(vecs[i].v));
         chk($sformatf("vec%0d wrap", i), 32'(w0), 32'(vecs[i].w));
      end

      // ---------------- live data follows the held channel ------------------
      rst0 = 0; en0 = 1; mode0 = 0; sel0 = 3; din0 = C_DIN4;
      tick();
      chk("live manual y", 32'(y0), 32'd3);
      din0[7:6] = 2'b01;
      tick();
      chk("live manual y new", 32'(y0), 32'd1);
      chk("live manual ch", 32'(ch0), 32'd3);
      mode0 = 1; din0[7:6] = 2'b10;
      tick();
      chk("live scan y", 32'(y0), 32'd2);
      chk("live scan ch", 32'(ch0), 32'd3);

      // ---------------- N=3: out-of-range select and 3-channel rotation -----
      tick();
      rst3 = 0; en3 = 1; mode3 = 0; sel3 = 1;
      tick();
      chk("n3 man y", 32'(y3), 32'd1);
      chk("n3 man ch", 32'(ch3), 32'd1);
      chk("n3 man vld", 32'(v3), 32'd1);
      sel3 = 3;
      tick();
      chk("n3 oor y", 32'(y3), 32'd0);
      chk("n3 oor vld", 32'(v3), 32'd0);
      chk("n3 oor ch", 32'(ch3), 32'd1);
      rst3 = 1;
      tick();
      rst3 = 0; mode3 = 1;
      for (int k = 0; k < 14; k++) begin
         tick();
         chk($sformatf("n3 scan%0d ch", k), 32'(ch3), 32'((k / 4) % 3));
         chk($sformatf("n3 scan%0d y", k), 32'(y3), 32'((k / 4) % 3));
         chk($sformatf("n3 scan%0d wrap", k), 32'(w3), 32'(k == 12));
      end

      // ---------------- DWELL=1: advance every cycle ------------------------
      rst1 = 0; en1 = 1; mode1 = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("d1 scan%0d ch", k), 32'(ch1), 32'(k % 4));
         chk($sformatf("d1 scan%0d y", k), 32'(y1), 32'(k % 4));
         chk($sformatf("d1 scan%0d wrap", k), 32'(w1), 32'((k > 0) && (k % 4 == 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
